ipm2l_apm_latency_ctrl: RTL

Run-time latency controller for `ipm2l_apm_distributed_shiftregister` built in `dynamic_latency` mode. It owns the shift register's `addr` and `rst` inputs. It accepts latency-change requests over a ready/ack handshake, optionally clears the register contents on a change, and generates `dout_valid`, which is high only when the shift register output holds data written after the latest latency change.

---
 rtl/ipm2l_apm_latency_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ipm2l_apm_latency_ctrl.sv
// Run-time latency controller for a dynamic-latency distributed shift register:
// owns its addr/rst, handles ready/ack latency changes and flags post-change output.
module ipm2l_apm_latency_ctrl #(
   parameter  int MAX_DEPTH     = 16,
   parameter  int INIT_LAT      = 4,
   parameter  int OUT_LAT       = 1,
   parameter  int CFG_WAIT_FILL = 1,
   parameter  int CLR_ON_CFG    = 1,
   localparam int AW = (MAX_DEPTH <= 16)  ? 4 :
                       (MAX_DEPTH <= 32)  ? 5 :
                       (MAX_DEPTH <= 64)  ? 6 :
                       (MAX_DEPTH <= 128) ? 7 :
                       (MAX_DEPTH <= 256) ? 8 :
                       (MAX_DEPTH <= 512) ? 9 : 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_req,
   input  logic [AW-1:0] cfg_lat,
   output logic          cfg_ready,
   output logic          cfg_ack,
   output logic          cfg_err,
   output logic [AW-1:0] sr_addr,
   output logic          sr_rst,
   output logic          dout_valid,
   output logic [AW-1:0] cur_lat
);

   localparam int          LAT_MAX   = (MAX_DEPTH < (1 << AW) - 1) ? MAX_DEPTH : (1 << AW) - 1;
   localparam logic [AW:0] LAT_MAX_V = (AW+1)'(LAT_MAX);

   typedef enum logic [1:0] {
      ST_CLR  = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [AW-1:0] r_lat;
   logic [AW:0]   r_cnt;
   logic          r_ack;
   logic          r_err;

   logic          w_ready;
   logic          w_accept;
   logic          w_lat_ok;
   logic          w_change;
   logic          w_bad;
   logic          w_fill_entry;
   logic          w_fill_done;
   logic [AW:0]   w_thr;

   assign w_accept     = cfg_req && w_ready;
   assign w_lat_ok     = (cfg_lat != '0) && ({1'b0, cfg_lat} <= LAT_MAX_V);
   assign w_change     = w_accept && w_lat_ok && (cfg_lat != r_lat);
   assign w_bad        = w_accept && !w_lat_ok;
   assign w_thr        = {1'b0, r_lat} + (AW+1)'(OUT_LAT);
   assign w_fill_done  = (r_cnt == w_thr - 1'b1);
   // A valid change while already filling restarts the count for the new latency
   assign w_fill_entry = (w_state_next == ST_FILL) && ((r_state != ST_FILL) || w_change);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_CLR;
         r_lat   <= AW'(INIT_LAT);
         r_cnt   <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_change)
            r_lat <= cfg_lat;
         if (w_fill_entry)
            r_cnt <= '0;
         else if (r_state == ST_FILL)
            r_cnt <= r_cnt + 1'b1;
         r_ack <= w_accept;
         r_err <= w_bad;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_CLR:  w_state_next = ST_FILL;
         ST_FILL: begin
            if (w_change)
               w_state_next = (CLR_ON_CFG != 0) ? ST_CLR : ST_FILL;
            else if (w_fill_done)
               w_state_next = ST_RUN;
         end
         ST_RUN: begin
            if (w_change)
               w_state_next = (CLR_ON_CFG != 0) ? ST_CLR : ST_FILL;
         end
         default: w_state_next = ST_CLR;
      endcase
   end

   always_comb begin
      w_ready    = 1'b0;
      sr_rst     = 1'b0;
      dout_valid = 1'b0;
      case (r_state)
         ST_CLR:  sr_rst = 1'b1;
         ST_FILL: w_ready = (CFG_WAIT_FILL == 0);
         ST_RUN: begin
            w_ready    = 1'b1;
            dout_valid = 1'b1;
         end
         default: sr_rst = 1'b1;
      endcase
   end

   assign cfg_ready = w_ready;
   assign cfg_ack   = r_ack;
   assign cfg_err   = r_err;
   assign sr_addr   = r_lat;
   assign cur_lat   = r_lat;

endmodule
